// File: rtl/rv_core_pkg.sv
// Shared core definitions: immediate-source encoding, RV32 opcodes, decode-slot states.
package rv_core_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    STALL = 2'b10
  } id_state_e;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: immediate source, operand-read flags, unknown-opcode flag.
module opcode_decode
  import rv_core_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_imm_src,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_unknown
);

  // Map opcode to extender select and register-read usage; unknown opcodes read nothing.
  always_comb begin
    o_imm_src  = IMM_I;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_unknown  = 1'b0;
    case (i_opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        o_imm_src  = IMM_I;
        o_uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        o_imm_src  = IMM_S;
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        o_imm_src  = IMM_B;
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OPC_JAL:            o_imm_src = IMM_J;
      OPC_LUI, OPC_AUIPC: o_imm_src = IMM_U;
      OPC_OP: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      default:            o_unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: one-entry valid/ready slot with load-use stall and flush.
// Optional feature macro: ILLEGAL_INSTR_TRAP_EN (flags unknown/compressed encodings to EX).
module id_stage_ctrl
  import rv_core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [31:0]     i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic            i_flush,
  input  logic            i_ex_load_valid,
  input  logic [4:0]      i_ex_load_rd,
  output logic            o_id_valid,
  input  logic            i_ex_ready,
  output logic [24:0]     o_id_instr,
  output logic [2:0]      o_immext_src,
  output logic [XLEN-1:0] o_id_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic            o_uses_rs1,
  output logic            o_uses_rs2,
  output logic            o_illegal
);

  // Counter reloads to N-1 so the slot spends exactly N cycles in STALL.
  localparam logic [1:0] StallInit = 2'(LOAD_USE_STALL - 1);

  id_state_e       r_state;
  id_state_e       w_state_nxt;
  logic [1:0]      r_cnt;
  logic [1:0]      w_cnt_nxt;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic            w_load;
  logic            w_unknown;
  logic            w_hazard;

  opcode_decode u_opcode_decode (
    .i_opcode   (r_instr[6:0]),
    .o_imm_src  (o_immext_src),
    .o_uses_rs1 (o_uses_rs1),
    .o_uses_rs2 (o_uses_rs2),
    .o_unknown  (w_unknown)
  );

  assign o_id_instr = r_instr[31:7];
  assign o_id_pc    = r_pc;
  assign o_rs1      = r_instr[19:15];
  assign o_rs2      = r_instr[24:20];
  assign o_rd       = r_instr[11:7];

  // x0 is never a real dependency, so a load to x0 cannot cause a stall.
  assign w_hazard = i_ex_load_valid && (i_ex_load_rd != 5'd0) &&
                    ((o_uses_rs1 && (o_rs1 == i_ex_load_rd)) ||
                     (o_uses_rs2 && (o_rs2 == i_ex_load_rd)));

`ifdef ILLEGAL_INSTR_TRAP_EN
  assign o_illegal = o_id_valid && (w_unknown || (r_instr[1:0] != 2'b11));
`else
  logic w_unused_unknown;
  assign w_unused_unknown = w_unknown;
  assign o_illegal        = 1'b0;
`endif

  // Next-state, handshake outputs and load enable; flush overrides everything last.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    o_id_valid  = 1'b0;
    o_if_ready  = 1'b0;
    case (r_state)
      EMPTY: begin
        o_if_ready = ~i_flush;
        if (i_if_valid) begin
          w_load      = 1'b1;
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (w_hazard) begin
          w_cnt_nxt   = StallInit;
          w_state_nxt = STALL;
        end else begin
          o_id_valid = 1'b1;
          o_if_ready = i_ex_ready & ~i_flush;
          if (i_ex_ready) begin
            if (i_if_valid) w_load = 1'b1;
            else            w_state_nxt = EMPTY;
          end
        end
      end
      STALL: begin
        if (r_cnt != 2'd0) w_cnt_nxt = r_cnt - 2'd1;
        else               w_state_nxt = FULL;
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (i_flush) begin
      w_state_nxt = EMPTY;
      w_cnt_nxt   = 2'd0;
      w_load      = 1'b0;
    end
  end

  // State, stall counter and held instruction/PC registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_cnt   <= 2'd0;
      r_instr <= 32'd0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_instr <= i_if_instr;
        r_pc    <= i_if_pc;
      end
    end
  end

endmodule
